// File: rtl/bus_owner_ctrl.sv
// Bus ownership lock downstream of the arbiter: holds the granted unit for a whole burst and counts beats.
// Optional stall abort is enabled by defining ARBITER_OWNER_TIMEOUT_EN.
module bus_owner_ctrl #(
    parameter int NUMUNITS     = 8,
    parameter int ADDRESSWIDTH = 3,
    parameter int DATAWIDTH    = 32,
    parameter int BURSTWIDTH   = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUMUNITS-1:0]            grant,
    input  logic [BURSTWIDTH*NUMUNITS-1:0] unit_len,
    input  logic [NUMUNITS-1:0]            unit_valid,
    input  logic [DATAWIDTH*NUMUNITS-1:0]  unit_data,
    input  logic                           bus_ready,
    output logic                           bus_valid,
    output logic [DATAWIDTH-1:0]           bus_data,
    output logic [ADDRESSWIDTH-1:0]        bus_owner,
    output logic                           bus_busy,
    output logic [NUMUNITS-1:0]            unit_done,
    output logic                           grant_err,
    output logic                           timeout_err
);

    typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

    state_t                  state, state_next;
    logic [ADDRESSWIDTH-1:0] owner_next;
    logic [BURSTWIDTH-1:0]   cnt, cnt_next;
    logic                    gerr_next;
    logic [ADDRESSWIDTH-1:0] grant_idx;
    logic                    grant_onehot;
    logic                    xfer;

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUMUNITS; i++) begin
            if (grant[i]) grant_idx = ADDRESSWIDTH'(i);
        end
        grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    end

    always_comb begin
        bus_valid = (state == BURST) && unit_valid[bus_owner];
        bus_data  = unit_data[bus_owner*DATAWIDTH +: DATAWIDTH];
        bus_busy  = (state == BURST);
        unit_done = (state == RELEASE) ? (NUMUNITS'(1) << bus_owner) : '0;
        xfer      = bus_valid && bus_ready;
    end

`ifdef ARBITER_OWNER_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT) + 1;
    logic [SW-1:0] stall, stall_next;
    logic          terr, terr_next;
    assign timeout_err = terr;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        owner_next = bus_owner;
        cnt_next   = cnt;
        gerr_next  = 1'b0;
`ifdef ARBITER_OWNER_TIMEOUT_EN
        stall_next = '0;
        terr_next  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (grant_onehot) begin
                    state_next = BURST;
                    owner_next = grant_idx;
                    cnt_next   = unit_len[grant_idx*BURSTWIDTH +: BURSTWIDTH];
                end else if (grant != '0) begin
                    gerr_next = 1'b1;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (cnt == '0) state_next = RELEASE;
                    else           cnt_next   = cnt - 1'b1;
                end
`ifdef ARBITER_OWNER_TIMEOUT_EN
                else if (stall == SW'(TIMEOUT - 1)) begin
                    state_next = RELEASE;
                    terr_next  = 1'b1;
                end else begin
                    stall_next = stall + 1'b1;
                end
`endif
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bus_owner <= '0;
            cnt       <= '0;
            grant_err <= 1'b0;
`ifdef ARBITER_OWNER_TIMEOUT_EN
            stall     <= '0;
            terr      <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            bus_owner <= owner_next;
            cnt       <= cnt_next;
            grant_err <= gerr_next;
`ifdef ARBITER_OWNER_TIMEOUT_EN
            stall     <= stall_next;
            terr      <= terr_next;
`endif
        end
    end

endmodule

// File: tb/tb_bus_owner_ctrl.sv
// Directed bench for bus_owner_ctrl: reset, bursts, backpressure, multi-hot grant, max length, stall.
module tb_bus_owner_ctrl;

    localparam int NU = 8;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int BW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NU-1:0]    grant;
    logic [BW*NU-1:0] unit_len;
    logic [NU-1:0]    unit_valid;
    logic [DW*NU-1:0] unit_data;
    logic             bus_ready;
    logic             bus_valid;
    logic [DW-1:0]    bus_data;
    logic [AW-1:0]    bus_owner;
    logic             bus_busy;
    logic [NU-1:0]    unit_done;
    logic             grant_err;
    logic             timeout_err;

    int tests = 0;
    int fails = 0;

    bus_owner_ctrl #(.NUMUNITS(NU), .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BURSTWIDTH(BW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .grant(grant), .unit_len(unit_len), .unit_valid(unit_valid),
        .unit_data(unit_data), .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
        .bus_owner(bus_owner), .bus_busy(bus_busy), .unit_done(unit_done), .grant_err(grant_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hD0D0_0000 | (i << 8) | i;
    endfunction

    initial begin
        rst        = 1'b0;
        grant      = 8'h04;
        unit_len   = '0;
        unit_valid = 8'hFF;
        bus_ready  = 1'b1;
        for (int i = 0; i < NU; i++) unit_data[i*DW +: DW] = pat(i);

        // reset held with a grant present
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", bus_busy, 0);
            check("rst_owner", bus_owner, 0);
            check("rst_done", unit_done, 0);
        end
        rst   = 1'b1;
        grant = '0;
        tick();
        check("idle_busy", bus_busy, 0);

        // basic 3-beat burst on unit 3
        unit_len[3*BW +: BW] = 4'd2;
        grant = 8'h08;
        tick();
        grant = '0;
        for (int b = 0; b < 3; b++) begin
            #1;
            check("b3_owner", bus_owner, 3);
            check("b3_busy", bus_busy, 1);
            check("b3_valid", bus_valid, 1);
            check("b3_data", bus_data, pat(3));
            check("b3_nodone", unit_done, 0);
            tick();
        end
        check("b3_done", unit_done, 8'h08);
        check("b3_rel_valid", bus_valid, 0);
        check("b3_rel_busy", bus_busy, 0);
        tick();
        check("b3_idle_done", unit_done, 0);
        check("b3_idle_busy", bus_busy, 0);

        // backpressure with grant change mid-burst, len=1
        unit_len[0*BW +: BW] = 4'd1;
        grant = 8'h01;
        tick();
        grant = 8'h80;
        for (int c = 0; c < 4; c++) begin
            bus_ready = c[0];
            #1;
            check("bp_owner", bus_owner, 0);
            check("bp_busy", bus_busy, 1);
            check("bp_valid", bus_valid, 1);
            tick();
        end
        grant     = '0;
        bus_ready = 1'b1;
        #1;
        check("bp_done", unit_done, 8'h01);
        check("bp_owner_rel", bus_owner, 0);
        tick();
        check("bp_idle", bus_busy, 0);

        // multi-hot grant
        grant = 8'h11;
        tick();
        grant = '0;
        #1;
        check("mh_err", grant_err, 1);
        check("mh_busy", bus_busy, 0);
        check("mh_owner", bus_owner, 0);
        tick();
        check("mh_err_clr", grant_err, 0);
        grant = 8'h10;
        tick();
        grant = '0;
        #1;
        check("g4_owner", bus_owner, 4);
        check("g4_data", bus_data, pat(4));
        check("g4_err", grant_err, 0);
        tick();
        check("g4_done", unit_done, 8'h10);
        tick();

        // max length 16 beats
        unit_len[5*BW +: BW] = 4'hF;
        grant = 8'h20;
        tick();
        grant = '0;
        for (int b = 0; b < 16; b++) begin
            #1;
            check("max_busy", bus_busy, 1);
            check("max_data", bus_data, pat(5));
            check("max_nodone", unit_done, 0);
            tick();
        end
        check("max_done", unit_done, 8'h20);
        tick();
        check("max_idle", bus_busy, 0);

        // reset after beat 5
        grant = 8'h20;
        tick();
        grant = '0;
        for (int b = 0; b < 5; b++) tick();
        check("mr_busy_pre", bus_busy, 1);
        rst = 1'b0;
        tick();
        check("mr_busy", bus_busy, 0);
        check("mr_done", unit_done, 0);
        check("mr_owner", bus_owner, 0);
        rst = 1'b1;
        tick();
        check("mr_done2", unit_done, 0);
        check("mr_busy2", bus_busy, 0);

        // stalled owner
        unit_valid[6] = 1'b0;
        grant = 8'h40;
        tick();
        grant = '0;
`ifdef ARBITER_OWNER_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            #1;
            check("to_busy", bus_busy, 1);
            check("to_err_low", timeout_err, 0);
            tick();
        end
        check("to_err", timeout_err, 1);
        check("to_done", unit_done, 8'h40);
        tick();
        check("to_err_clr", timeout_err, 0);
        check("to_idle", bus_busy, 0);
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            check("st_busy", bus_busy, 1);
            check("st_valid", bus_valid, 0);
            check("st_terr", timeout_err, 0);
            tick();
        end
        unit_valid[6] = 1'b1;
        tick();
        check("st_done", unit_done, 8'h40);
        tick();
        check("st_idle", bus_busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_owner_ctrl.md
Name: bus_owner_ctrl

Overview:
- Sits directly downstream of the bus arbiter and consumes its registered one-hot grant vector.
- Locks bus ownership to the granted unit for a whole burst, muxes that unit's data onto the shared bus, and counts beats with a ready/valid handshake.
- Pulses a per-unit done so the master drops its request. Arbiter grant changes during a burst are ignored.

Parameters:
NUMUNITS, 8, number of bus masters
ADDRESSWIDTH, 3, bits to index NUMUNITS
DATAWIDTH, 32, bus data width
BURSTWIDTH, 4, width of per-unit burst length field
TIMEOUT, 16, stall cycles before abort (TIMEOUT_EN only)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
grant  input  NUMUNITS  registered one-hot grant from arbiter
unit_len  input  BURSTWIDTH*NUMUNITS  packed per-unit burst length, unit i at [i*BURSTWIDTH +: BURSTWIDTH]; beats = len+1
unit_valid  input  NUMUNITS  per-unit data valid
unit_data  input  DATAWIDTH*NUMUNITS  packed per-unit data
bus_ready  input  1  slave accepts beat
bus_valid  output  1  beat present on bus
bus_data  output  DATAWIDTH  owner's data
bus_owner  output  ADDRESSWIDTH  index of current owner
bus_busy  output  1  burst in progress
unit_done  output  NUMUNITS  one-cycle pulse to owner at burst end
grant_err  output  1  one-cycle pulse: non-one-hot grant seen in IDLE
timeout_err  output  1  one-cycle pulse on abort (tied 0 without TIMEOUT_EN)

Behaviour:
- Clock and reset: single clock clk. rst is sampled on posedge clk; rst==0 forces state IDLE.
- Reset values: bus_owner=0, bus_busy=0, unit_done=0, grant_err=0, timeout_err=0, beat counter=0.
- State machine: IDLE, BURST, RELEASE.
- IDLE:
  - grant==0: stay in IDLE.
  - grant exactly one-hot (bit i): next cycle bus_owner=i, counter=unit_len[i], state=BURST, bus_busy=1.
  - grant with >1 bit set: grant_err pulses next cycle, stay in IDLE, owner unchanged.
- BURST:
  - bus_valid = unit_valid[bus_owner] (combinational from registered state/owner).
  - bus_data = unit_data[bus_owner] (combinational mux). bus_data is don't-care when bus_valid=0.
  - A beat transfers when bus_valid && bus_ready.
  - Transfer with counter!=0: decrement counter.
  - Transfer with counter==0 (last beat): next cycle state=RELEASE, unit_done[bus_owner]=1, bus_busy=0.
  - No transfer: hold.
  - grant input is ignored entirely.
- RELEASE: exactly one cycle, bus_valid=0, unit_done pulse active. Next state IDLE.
  - Grant seen in RELEASE is ignored. The arbiter re-grants after the master drops its request.
- Outputs outside BURST: bus_valid=0.
- Latency: grant at posedge N → bus_valid may assert in cycle N+1. Last beat at N → done in cycle N+1. Earliest next grant accepted in cycle N+2.
- Boundaries:
  - len=0 is a 1-beat burst.
  - len=2^BURSTWIDTH-1 is 16 beats; the counter never wraps.
  - unit_valid may drop mid-burst; the counter holds.
- Reset mid-burst: returns to IDLE the next edge, no done pulse.

Optional Feature:
- Macro: ARBITER_OWNER_TIMEOUT_EN.
- When defined:
  - A stall counter runs in BURST. It clears on each transfer and increments on each non-transfer cycle.
  - When it reaches TIMEOUT-1: next cycle state=RELEASE, timeout_err=1 and unit_done[bus_owner]=1 for one cycle.
  - The stall counter clears in IDLE and on reset.
- When undefined: no stall counter, timeout_err tied to 0, and a burst may stall indefinitely.

Test Plan:
- Reset: rst=0 for 2 cycles with grant=8'h04 → bus_busy=0, bus_owner=0, unit_done=0 throughout.
- Basic burst: grant=8'h08, unit_len[3]=2, unit_valid[3]=1, bus_ready=1 → bus_owner=3, three beats of unit_data[3] on consecutive cycles, then unit_done=8'h08 for one cycle, then IDLE.
- Backpressure and grant lock: grant=8'h01, len=1, bus_ready toggling 0/1, grant changes to 8'h80 mid-burst → owner stays 0, exactly 2 transfers, done=8'h01.
- Multi-hot grant: grant=8'h11 in IDLE → grant_err pulses, bus_busy stays 0. Then grant=8'h10 → owner=4.
- Max length and reset: len=4'hF, full 16 beats with done after the 16th. Repeat with rst=0 after beat 5 → IDLE, no done.
- ARBITER_OWNER_TIMEOUT_EN defined, TIMEOUT=16: owner with unit_valid=0 for 16 cycles → timeout_err=1 and unit_done pulse, then IDLE. Undefined: bus_busy stays 1.
